// File: rtl/raifes_hasti_bram_bridge_pkg.sv
// Shared HASTI bus constants and the RAMB36 port address helper used by the
// HASTI-to-BRAM bridge and by any future HASTI slaves.
package raifes_hasti_bram_bridge_pkg;

    localparam logic [1:0] HASTI_TRANS_IDLE   = 2'b00;
    localparam logic [1:0] HASTI_TRANS_BUSY   = 2'b01;
    localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HASTI_TRANS_SEQ    = 2'b11;

    localparam logic [2:0] HASTI_SIZE_BYTE = 3'd0;
    localparam logic [2:0] HASTI_SIZE_HALF = 3'd1;
    localparam logic [2:0] HASTI_SIZE_WORD = 3'd2;

    localparam logic HASTI_RESP_OKAY  = 1'b0;
    localparam logic HASTI_RESP_ERROR = 1'b1;

    // RAMB36 ports take the word index left-justified above the bit-select field
    localparam int RAMB_ADDR_SHIFT = 5;

    function automatic logic [31:0] ramb_addr(input logic [31:0] word);
        return word << RAMB_ADDR_SHIFT;
    endfunction

endpackage

// File: rtl/raifes_hasti_bram_bridge_if.sv
// HASTI (AHB-Lite) slave-side bus bundle; hready_in is the bus-wide HREADY.
interface raifes_hasti_bram_bridge_if;

    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hready_in;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output hsel, haddr, hwrite, hsize, htrans, hready_in, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, htrans, hready_in, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/raifes_hasti_bram_bridge_wmask.sv
// Byte-lane mask for a HASTI transfer, flagging misaligned or oversized sizes.
module raifes_hasti_wmask
    import raifes_hasti_bram_bridge_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] mask_o,
    output logic       err_o
);

    always_comb begin
        mask_o = 4'b0000;
        err_o  = 1'b0;
        case (hsize_i)
            HASTI_SIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
            HASTI_SIZE_HALF: begin
                mask_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                err_o  = addr_lo_i[0];
            end
            HASTI_SIZE_WORD: begin
                mask_o = 4'b1111;
                err_o  = |addr_lo_i;
            end
            default: err_o = 1'b1;
        endcase
        // An errored transfer must never carry lane enables downstream
        if (err_o) begin
            mask_o = 4'b0000;
        end
    end

endmodule

// File: rtl/raifes_hasti_bram_bridge.sv
// HASTI slave driving one single-port RAMB36 port: zero wait states except a
// single stall for a read that directly follows a write, two-cycle ERROR.
module raifes_hasti_bram_bridge
    import raifes_hasti_bram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    raifes_hasti_bram_bridge_if.slave  bus,
    output logic                       ram_en_o,
    output logic [3:0]                 ram_we_o,
    output logic [31:0]                ram_addr_o,
    output logic [31:0]                ram_di_o,
    input  logic [31:0]                ram_do_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_PEND,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              mask_q, mask_d;
    logic                    hready_q, hready_d;
    logic                    hresp_q, hresp_d;

    logic [3:0]              size_mask;
    logic                    size_err;
    logic                    accept;
    logic                    take;
    logic [ADDR_WIDTH-1:0]   bus_word;

    logic                    unused_bus_bits;
    assign unused_bus_bits = &{1'b0, bus.haddr[31:ADDR_WIDTH+2], bus.htrans[0]};

    raifes_hasti_wmask u_wmask (
        .hsize_i   (bus.hsize),
        .addr_lo_i (bus.haddr[1:0]),
        .mask_o    (size_mask),
        .err_o     (size_err)
    );

    assign bus_word = bus.haddr[ADDR_WIDTH+1:2];
    assign accept   = bus.hsel & bus.hready_in & bus.htrans[1];
    // Stall states ignore the bus; only a completing data phase can take a new one
    assign take     = accept & hready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        case (state_q)
            ST_ERR1:    state_d = ST_ERR2;
            ST_RD_PEND: state_d = ST_RD;
            default: begin
                if (!take) begin
                    state_d = ST_IDLE;
                end else if (size_err) begin
                    state_d = ST_ERR1;
                end else if (bus.hwrite) begin
                    state_d = ST_WR;
                end else if (state_q == ST_WR) begin
                    state_d = ST_RD_PEND;
                end else begin
                    state_d = ST_RD;
                end
                if (take && !size_err) begin
                    addr_d = bus_word;
                    mask_d = size_mask;
                end
            end
        endcase
        hready_d = !((state_d == ST_ERR1) || (state_d == ST_RD_PEND));
        hresp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            mask_q   <= 4'b0000;
            hready_q <= 1'b1;
            hresp_q  <= HASTI_RESP_OKAY;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mask_q   <= mask_d;
            hready_q <= hready_d;
            hresp_q  <= hresp_d;
        end
    end

    // The port is owned by a write data phase first, then a deferred read,
    // and only otherwise by a read issued straight from the address phase.
    always_comb begin
        ram_en_o   = 1'b0;
        ram_we_o   = 4'b0000;
        ram_addr_o = 32'd0;
        ram_di_o   = 32'd0;
        if (!rst_i) begin
            if (state_q == ST_WR) begin
                ram_en_o   = 1'b1;
                ram_we_o   = mask_q;
                ram_addr_o = ramb_addr(32'(addr_q));
                ram_di_o   = bus.hwdata;
            end else if (state_q == ST_RD_PEND) begin
                ram_en_o   = 1'b1;
                ram_addr_o = ramb_addr(32'(addr_q));
            end else if (take && !bus.hwrite && !size_err) begin
                ram_en_o   = 1'b1;
                ram_addr_o = ramb_addr(32'(bus_word));
            end
        end
    end

    assign bus.hrdata = ram_do_i;
    assign bus.hready = hready_q;
    assign bus.hresp  = hresp_q;

endmodule

// File: doc/raifes_hasti_bram_bridge.md
# raifes_hasti_bram_bridge

- HASTI (AHB-Lite) slave that turns pipelined CPU bus transfers into single-port RAMB36 port signals.
- Sits directly upstream of the on-chip RAMB36 and drives one of its ports (A or B).
- Byte/halfword/word accesses use byte lanes.
- Zero wait states except one stall for a read directly after a write; unaligned or oversized transfers get a two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 16, word-index width; RAM word = haddr[ADDR_WIDTH+1:2]; haddr bits above are ignored (decoding via hsel).
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  bus/RAM clock
- reset  in  1  asynchronous, active-high
- hsel  in  1  slave select
- haddr  in  32  byte address
- hwrite  in  1  1 = write
- hsize  in  3  0 byte, 1 half, 2 word
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hready_in  in  1  bus-wide HREADY (previous data phase done)
- hwdata  in  32  lane-aligned write data (data phase)
- hrdata  out  32  read data
- hready  out  1  transfer-done
- hresp  out  1  0 OKAY, 1 ERROR
- ram_en  out  1  RAM port enable
- ram_we  out  4  byte write enables
- ram_addr  out  32  word index << 5
- ram_di  out  32  write data
- ram_do  in  32  RAM output (registered, 1-cycle latency)

## Operation
- A transfer is accepted when hsel & hready_in & htrans[1].
- IDLE/BUSY transfers, or hsel=0: OKAY, zero wait, no RAM access.
- Byte mask:
  - size 0: 4'b0001<<haddr[1:0].
  - size 1: 4'b0011<<{haddr[1],1'b0}; requires haddr[0]=0.
  - size 2: 4'b1111; requires haddr[1:0]=0.
  - size>2 or misaligned: error.
- States:
  - IDLE: no data phase pending.
  - WR: write data phase.
  - RD: read data phase.
  - RD_PEND: read held off by a write.
  - ERR1, ERR2: error response.
- From any state with hready=1:
  - Accepted read → RD, except when the current state is WR → RD_PEND.
  - Accepted write → WR.
  - Accepted error → ERR1.
  - Otherwise → IDLE.
- ERR1 → ERR2 unconditionally. RD_PEND → RD unconditionally.
- Read issue: ram_en=1, ram_we=0, ram_addr=word<<5.
  - Issued combinationally in the address-phase cycle if the port is free.
  - Otherwise issued from the registered address in RD_PEND.
- Write: in WR, ram_en=1, ram_we=registered mask, ram_addr=registered word<<5, ram_di=hwdata.
- hrdata=ram_do. Valid only in RD with hready=1; don't-care elsewhere.
- Errored transfers never assert ram_en.

## Timing
- Reset (async), all held while asserted:
  - state=IDLE, hready=1, hresp=0
  - ram_en=0, ram_we=0, ram_addr=0, ram_di=0
  - registered address/mask/write cleared
- Reset mid-transfer discards pending write or read; no RAM write occurs.
- Read: address phase cycle T → hrdata valid, hready=1 at T+1.
- Write: address phase T → RAM written at rising edge ending T+1; hready=1 at T+1.
- Read immediately after write: hready=1 at T+1 (write done, read accepted), RAM read issued T+2 with hready=0, data at T+3 with hready=1. Exactly one wait state.
  - Same-word read after write returns the new data.
- Back-to-back writes, or write after read: zero wait.
- Error: ERR1 hready=0, hresp=1; ERR2 hready=1, hresp=1.
  - An address phase sampled in ERR2 is treated as a normal new transfer.
- ram_we is nonzero only while ram_en=1.

## Structure
- raifes_hasti_constants.vh, shared header:
  - HASTI_TRANS_*, HASTI_SIZE_*, HASTI_RESP_* (existing)
  - RAM address shift constant RAMB_ADDR_SHIFT=5 (new)
- State encodings stay local.
- One combinational sub-module, raifes_hasti_wmask: (hsize, haddr[1:0]) → 4-bit mask + misaligned/oversize error flag.
  - Reused by future HASTI slaves.

## Test plan
- Write word 0xDEADBEEF to 0x0000_0010, then read it back:
  - write cycle: ram_addr=0x80, ram_we=4'hF
  - read: hrdata=0xDEADBEEF one cycle after the address phase; no wait states
- Byte write 0x41 to 0x0003_0004:
  - ram_addr=0x0018_0020 (word 49153), ram_we=4'b0001, ram_di[7:0]=0x41
  - the RAM prints "A"
- Halfword write 0xCAFE at 0x22 over prior word 0x11223344 at 0x20: ram_we=4'b1100; readback 0xCAFE3344.
- Write 0x12345678 to 0x40 followed immediately by a read of 0x40: exactly one hready=0 cycle, then hrdata=0x12345678.
- Halfword at 0x01, and hsize=3 at 0x00:
  - each gives hready=0/hresp=1, then hready=1/hresp=1
  - ram_en never asserted
  - a following read of 0x00 proceeds normally
- Assert reset during the data phase of a write to 0x80: ram_we stays 0; after release, a read of 0x80 returns the old value; hready=1, hresp=0.
